// File: rtl/muldiv_ctrl.sv
// Iterative 32-bit multiply/divide sequencer owning the HI/LO pair.
// Runs MULT/MULTU as a shift-add loop and DIV/DIVU as a restoring divide, with a fix-up cycle for signs.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] s1val,
    input  logic [31:0] s2val,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [2:0] OP_MFHI = 3'd4;
    localparam logic [2:0] OP_MFLO = 3'd5;
    localparam logic [2:0] OP_MTHI = 3'd6;
    localparam logic [2:0] OP_MTLO = 3'd7;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [63:0] acc_reg, acc_next;
    logic [31:0] opa_reg, opa_next;
    logic [31:0] opb_reg, opb_next;
    logic        is_div_reg, is_div_next;
    logic        qsign_reg, qsign_next;
    logic        rsign_reg, rsign_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    logic        accept;
    logic        s1_neg, s2_neg;
    logic [31:0] abs_s1, abs_s2;
    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic [63:0] neg_acc;

    assign stall  = start && (state_reg != IDLE);
    assign accept = start && !stall;
    assign busy   = busy_reg;
    assign done   = done_reg;
    assign hi     = hi_reg;
    assign lo     = lo_reg;

    always_comb begin
        result = 32'd0;
        if (accept && op == OP_MFHI)
            result = hi_reg;
        else if (accept && op == OP_MFLO)
            result = lo_reg;
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        opa_next    = opa_reg;
        opb_next    = opb_reg;
        is_div_next = is_div_reg;
        qsign_next  = qsign_reg;
        rsign_next  = rsign_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;

        // op[0] marks the unsigned variants, which skip the magnitude step
        s1_neg    = !op[0] && s1val[31];
        s2_neg    = !op[0] && s2val[31];
        abs_s1    = s1_neg ? (~s1val + 32'd1) : s1val;
        abs_s2    = s2_neg ? (~s2val + 32'd1) : s2val;
        mul_sum   = {1'b0, acc_reg[63:32]} + {1'b0, opa_reg};
        div_trial = {acc_reg[63:32], opa_reg[31]} - {1'b0, opb_reg};
        neg_acc   = ~acc_reg + 64'd1;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (!op[2]) begin
                        state_next  = RUN;
                        cnt_next    = 5'd0;
                        acc_next    = 64'd0;
                        opa_next    = abs_s1;
                        opb_next    = abs_s2;
                        is_div_next = op[1];
                        // a zero divisor leaves the all-ones quotient un-negated
                        qsign_next  = (s1_neg ^ s2_neg) && !(op[1] && s2val == 32'd0);
                        rsign_next  = s1_neg;
                    end else if (op == OP_MTHI) begin
                        hi_next = s1val;
                    end else if (op == OP_MTLO) begin
                        lo_next = s1val;
                    end
                end
            end
            RUN: begin
                cnt_next = cnt_reg + 5'd1;
                if (is_div_reg) begin
                    // bit 32 of the trial difference is the borrow
                    if (!div_trial[32])
                        acc_next = {div_trial[31:0], acc_reg[30:0], 1'b1};
                    else
                        acc_next = {acc_reg[62:32], opa_reg[31], acc_reg[30:0], 1'b0};
                    opa_next = {opa_reg[30:0], 1'b0};
                end else begin
                    if (opb_reg[0])
                        acc_next = {mul_sum, acc_reg[31:1]};
                    else
                        acc_next = {1'b0, acc_reg[63:1]};
                    opb_next = {1'b0, opb_reg[31:1]};
                end
                if (cnt_reg == 5'd31)
                    state_next = FIX;
            end
            FIX: begin
                state_next = IDLE;
                if (is_div_reg) begin
                    lo_next = qsign_reg ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
                    hi_next = rsign_reg ? (~acc_reg[63:32] + 32'd1) : acc_reg[63:32];
                end else begin
                    {hi_next, lo_next} = qsign_reg ? neg_acc : acc_reg;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
        done_next = (state_next == FIX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= 5'd0;
            acc_reg    <= 64'd0;
            opa_reg    <= 32'd0;
            opb_reg    <= 32'd0;
            is_div_reg <= 1'b0;
            qsign_reg  <= 1'b0;
            rsign_reg  <= 1'b0;
            hi_reg     <= 32'd0;
            lo_reg     <= 32'd0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            opa_reg    <= opa_next;
            opb_reg    <= opb_next;
            is_div_reg <= is_div_next;
            qsign_reg  <= qsign_next;
            rsign_reg  <= rsign_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected HI/LO and MF results,
// a negedge monitor checks them together with busy/done/stall timing.
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] s1val = 32'd0;
    logic [31:0] s2val = 32'd0;
    logic        stall, busy, done;
    logic [31:0] result, hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [63:0] arith_q[$];
    logic [31:0] mf_q[$];
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    bit inflight = 1'b0;
    int acc_a    = 0;

    muldiv_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .s1val(s1val), .s2val(s2val), .stall(stall), .busy(busy),
        .done(done), .result(result), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the architectural result of one operation, from plain arithmetic.
    function automatic logic [63:0] calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd0: calc = 64'(sa * sb);
            3'd1: calc = ua * ub;
            3'd2: begin
                if (b == 32'd0) calc = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    calc = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) calc = {a, 32'hFFFFFFFF};
                else calc = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    task automatic push_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        case (o)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                r = calc(o, a, b);
                arith_q.push_back(r);
                {model_hi, model_lo} = r;
            end
            3'd4: mf_q.push_back(model_hi);
            3'd5: mf_q.push_back(model_lo);
            3'd6: model_hi = a;
            default: model_lo = a;
        endcase
    endtask

    // Present a request and hold it until accepted; returns 1ns after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int waited = 0;
        push_model(o, a, b);
        $display("[TB] issue op=%0d s1=%h s2=%h", o, a, b);
        start = 1'b1; op = o; s1val = a; s2val = b;
        @(negedge clk);
        while (stall && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (stall) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: stall still %b after %0d cycles, required 0", stall, waited);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: pick = 32'd0;
            1: pick = 32'd1;
            2: pick = 32'hFFFFFFFF;
            3: pick = 32'h80000000;
            default: pick = $urandom;
        endcase
    endfunction

    // Monitor: timing of busy/done/stall, HI/LO after each operation, MF results.
    always @(negedge clk) begin
        logic exp_busy;
        logic [63:0] e;
        logic mf_acc;
        if (reset) begin
            inflight = 1'b0;
        end else begin
            exp_busy = inflight && cyc >= acc_a && cyc <= acc_a + 32;
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("done", {31'd0, done}, {31'd0, inflight && cyc == acc_a + 32});
            check("stall", {31'd0, stall}, {31'd0, start && exp_busy});
            if (inflight && cyc == acc_a + 33) begin
                inflight = 1'b0;
                if (arith_q.size() == 0) begin
                    check("arith_q_empty", 32'd1, 32'd0);
                end else begin
                    e = arith_q.pop_front();
                    check("hi", hi, e[63:32]);
                    check("lo", lo, e[31:0]);
                    $display("[TB] op done hi=%h lo=%h", hi, lo);
                end
            end
            mf_acc = start && !stall && (op == 3'd4 || op == 3'd5);
            if (start && !stall && !op[2]) begin
                inflight = 1'b1;
                acc_a = cyc + 1;
            end
            if (mf_acc) begin
                if (mf_q.size() == 0) begin
                    check("mf_q_empty", 32'd1, 32'd0);
                end else begin
                    e[31:0] = mf_q.pop_front();
                    check(op == 3'd4 ? "mfhi" : "mflo", result, e[31:0]);
                    $display("[TB] mf op=%0d result=%h", op, result);
                end
            end else begin
                check("result_idle", result, 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;

        // Directed cases
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(3'd0, 32'hFFFFFFFD, 32'd5);
        issue(3'd0, 32'h80000000, 32'h80000000);
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        issue(3'd3, 32'd7, 32'd0);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        issue(3'd2, 32'hFFFFFFF9, 32'd0);

        // MFHI held from cycle 5 of a MULT 6x7, then MFLO
        issue(3'd0, 32'd6, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        issue(3'd4, 32'd0, 32'd0);
        issue(3'd5, 32'd0, 32'd0);

        // MTHI then MFHI in the next cycle; MTLO while busy
        issue(3'd6, 32'h00001234, 32'd0);
        issue(3'd4, 32'd0, 32'd0);
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        issue(3'd7, 32'hCAFEF00D, 32'd0);
        issue(3'd5, 32'd0, 32'd0);
        issue(3'd4, 32'd0, 32'd0);

        // Random mix
        for (int t = 0; t < 50; t++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Reset in cycle 10 of a DIV aborts it and clears HI/LO
        waited = 0;
        while (inflight && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        #1;
        issue(3'd6, 32'h5555AAAA, 32'd0);
        issue(3'd2, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        void'(arith_q.pop_back());
        model_hi = 32'd0;
        model_lo = 32'd0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (30) @(posedge clk);
        #1;
        issue(3'd5, 32'd0, 32'd0);
        issue(3'd4, 32'd0, 32'd0);

        // Drain
        waited = 0;
        while (inflight && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        check("drain_inflight", {31'd0, inflight}, 32'd0);
        check("arith_q_left", arith_q.size(), 32'd0);
        check("mf_q_left", mf_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer that owns the HI/LO register pair for the MIPS core. It takes MULT/MULTU/DIV/DIVU from the execute stage and runs them as 32-step shift-add and restoring-divide loops. It services MFHI/MFLO/MTHI/MTLO and raises a stall toward the pipeline while a HI/LO access would race an operation in flight. This block replaces the single-cycle `*`, `/` and `%` paths and the HI/LO handling in the ALU.

## Interface
- No parameters; the datapath is fixed at 32 bits and the iteration count is fixed at 32.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  the request in `op` is valid this cycle.
- `op`  in  3  request code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
- `s1val`  in  32  rs operand (multiplicand or dividend; MT* source).
- `s2val`  in  32  rt operand (multiplier or divisor).
- `stall`  out  1  combinational; the request is not accepted this cycle and the requester must hold `start`, `op` and operands.
- `busy`  out  1  registered; an operation is in flight.
- `done`  out  1  registered; one-cycle pulse in the last cycle of an operation.
- `result`  out  32  combinational; HI for MFHI and LO for MFLO when `start` is high and `stall` is low, otherwise 0.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- FSM states:
  - IDLE → RUN on an accepted MULT, MULTU, DIV or DIVU.
  - RUN → RUN for 32 iterations, counted by a 5-bit counter.
  - RUN → FIX after iteration 31.
  - FIX → IDLE, always.
- Acceptance: a request is accepted when `start` is high and `stall` is low.
- `stall` = `start` and (state is RUN or FIX). This covers every op, so there is no overlap and no queueing.
- Accept of MULT/DIV in IDLE:
  - Latch |s1val| and |s2val|. Signed ops take the magnitude; unsigned ops pass the value through.
  - Latch the sign flags: product/quotient sign = s1[31]^s2[31]; remainder sign = s1[31]. Both flags are 0 for unsigned ops.
  - Clear the 64-bit accumulator and the counter.
- MUL iteration: if multiplier LSB is 1, add the multiplicand into accumulator[63:32]. Then shift the {carry, accumulator} pair right by one.
- DIV iteration, restoring: shift {remainder, quotient} left by one. Trial-subtract the divisor from the remainder. If there is no borrow, keep the difference and set quotient bit 0.
- FIX for MUL: {hi,lo} ← the 64-bit product, two's-complement negated if the product sign flag is set.
- FIX for DIV:
  - lo ← quotient, negated if the quotient sign flag is set.
  - hi ← remainder, negated if the remainder sign flag is set.
- Divide by zero: no trap and no fix-up. The result is lo = 0xFFFFFFFF and hi = s1val, for both signed and unsigned divides.
- Signed DIV of 0x80000000 by 0xFFFFFFFF: lo = 0x80000000, hi = 0. This falls out of the magnitude arithmetic.
- MTHI/MTLO in IDLE: hi or lo ← s1val at the accepting edge.
- MFHI/MFLO in IDLE: `result` presents the current register value in the same cycle. No state change.
- HI/LO are written only in FIX or by MT*. They are stable during RUN.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0. With `start`=0, `stall`=0 and `result`=0.
- Reset during RUN or FIX aborts the operation: state IDLE, no `done` pulse, and HI/LO are cleared on that edge.
- MULT/DIV accepted at edge 0:
  - `busy` is high in cycles 1–33.
  - RUN occupies cycles 1–32.
  - FIX is cycle 33, with `done`=1.
  - New hi/lo are visible from cycle 34.
  - `busy`=0 in cycle 34.
- A request presented during the FIX cycle is stalled and accepted in cycle 34. MFHI/MFLO therefore always see the completed result.
- Back-to-back MULT/DIV: issue-to-issue distance is at least 34 cycles.
- MT*/MF* issued in IDLE complete in one cycle. An MTHI at edge n is visible to MFHI in cycle n+1.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF accepted at cycle 0 → `done` in cycle 33; hi=0xFFFFFFFE, lo=0x00000001 in cycle 34.
- MULT 0xFFFFFFFD (−3) × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 → lo=0xFFFFFFFF, hi=7. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MFHI held from cycle 5 after a MULT 6×7 issued at cycle 0 → `stall`=1 in cycles 5–33. Accepted in cycle 34 with `result`=0; a following MFLO returns 42.
- `reset` asserted in cycle 10 of a DIV → `busy`=0, hi=lo=0 from cycle 11, and `done` never pulses.
- MTHI 0x1234 then MFHI in the next cycle → `result`=0x1234 with `stall`=0. MTLO while `busy` → stalled until cycle 34, then lo=s1val.
